gray_codec: RTL

- Parametrised, pipelined binary/Gray code converter with valid/ready streaming on input and output.
- Each transfer carries its own mode bit: encode (binary -> Gray) or decode (Gray -> binary).
- Successor to the fixed 4-bit combinational BCD-to-Gray converter. Adds arbitrary width, bidirectional conversion, backpressure and an optional adjacency checker.
- Sits between counter/position sources and CDC or encoder-interface logic.

---
 rtl/gray_codec_pkg.sv | 38 +++
 rtl/gray_skid_buf.sv | 56 +++++
 rtl/gray_codec.sv | 111 +++++++++++
 3 files changed

// File: rtl/gray_codec_pkg.sv
// gray_codec_pkg
//   Shared types and conversion helpers for the gray_codec block.
//   Helpers operate on a GC_MAX_WIDTH-bit word; callers zero-extend their
//   operand and take the low WIDTH bits of the result. Zero upper bits make
//   the wide result identical to an exact WIDTH-bit conversion.
package gray_codec_pkg;

  localparam int GC_MAX_WIDTH = 64;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  typedef logic [GC_MAX_WIDTH-1:0] gc_word_t;

  // g[i] = b[i] ^ b[i+1]; the top bit passes through because the bit above it is zero.
  function automatic gc_word_t bin2gray(input gc_word_t b);
    return b ^ (b >> 1);
  endfunction

  // MSB-first prefix XOR.
  function automatic gc_word_t gray2bin(input gc_word_t g);
    gc_word_t b;
    b = '0;
    b[GC_MAX_WIDTH-1] = g[GC_MAX_WIDTH-1];
    for (int i = GC_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_one_hot(input gc_word_t v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/gray_skid_buf.sv
// gray_skid_buf
//   Generic two-entry valid/ready buffer: an output register plus one skid
//   register. s_ready is a register output (inverse of skid occupancy), so
//   there is no combinational path from m_ready to s_ready.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_valid/s_ready   upstream handshake, s_data payload in
//   m_valid/m_ready   downstream handshake, m_data payload out (held until accepted)
module gray_skid_buf #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         in_fire;
  logic         out_free;

  assign s_ready  = !skid_valid;
  assign in_fire  = s_valid && s_ready;
  // Output register can take a new word this edge: empty, or draining.
  assign out_free = !m_valid || m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        // Skid always holds the older word; in_fire is low here.
        m_valid    <= 1'b1;
        m_data     <= skid_data;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= s_data;
    end
  end

endmodule

// File: rtl/gray_codec.sv
// gray_codec
//   Pipelined binary/Gray converter with valid/ready on both sides. Each word
//   carries its own mode (0 = encode bin->Gray, 1 = decode Gray->bin). The
//   conversion is done on entry, so the skid buffer holds converted data.
//   Latency one cycle, one word per cycle with m_ready held high.
//   Optional adjacency checker enabled by macro GRAY_CODEC_STEP_CHK_EN.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   s_valid, s_ready, s_data, s_mode   input stream
//   m_valid, m_ready, m_data, m_mode   output stream
//   m_step_err                  (GRAY_CODEC_STEP_CHK_EN only) encode output
//                               differs from previous encode output in != 1 bit
// WIDTH must be between 2 and GC_MAX_WIDTH.
module gray_codec
  import gray_codec_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_mode,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_mode
`ifdef GRAY_CODEC_STEP_CHK_EN
  ,
  output logic             m_step_err
`endif
);

`ifdef GRAY_CODEC_STEP_CHK_EN
  localparam int PW = WIDTH + 2;
`else
  localparam int PW = WIDTH + 1;
`endif

  gc_word_t         data_ext;
  gc_word_t         conv_ext;
  logic [WIDTH-1:0] conv;
  logic [PW-1:0]    in_payload;
  logic [PW-1:0]    out_payload;

  assign data_ext = gc_word_t'(s_data);
  assign conv_ext = (mode_e'(s_mode) == MODE_DEC) ? gray2bin(data_ext) : bin2gray(data_ext);
  assign conv     = conv_ext[WIDTH-1:0];

  // Upper bits are always zero for a zero-extended operand.
  generate
    if (WIDTH < GC_MAX_WIDTH) begin : g_hi
      logic unused_hi;
      assign unused_hi = |conv_ext[GC_MAX_WIDTH-1:WIDTH];
    end
  endgenerate

`ifdef GRAY_CODEC_STEP_CHK_EN
  // Words reach the output register in acceptance order and reset flushes
  // both the pipeline and the history, so tracking history at acceptance
  // gives the same flags as tracking it at output-register load.
  logic             hist_valid;
  logic [WIDTH-1:0] hist;
  logic             is_enc;
  logic             step_err;

  assign is_enc = (mode_e'(s_mode) == MODE_ENC);

  always_comb begin
    step_err = 1'b0;
    if (is_enc && hist_valid) begin
      step_err = !is_one_hot(gc_word_t'(conv ^ hist));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_valid <= 1'b0;
      hist       <= '0;
    end else if (s_valid && s_ready && is_enc) begin
      hist_valid <= 1'b1;
      hist       <= conv;
    end
  end

  assign in_payload = {step_err, s_mode, conv};
`else
  assign in_payload = {s_mode, conv};
`endif

  gray_skid_buf #(
    .W(PW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (in_payload),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (out_payload)
  );

  assign m_data = out_payload[WIDTH-1:0];
  assign m_mode = out_payload[WIDTH];
`ifdef GRAY_CODEC_STEP_CHK_EN
  assign m_step_err = out_payload[WIDTH+1];
`endif

endmodule
